// File: rtl/vga_timing_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : vga_timing_gen                                           |
// | Description : Parametrised VGA timing generator with programmable      |
// |               porch/sync timing and polarity, pixel fetch coordinates, |
// |               frame/line strobes and a pattern mux (solid, colour      |
// |               bars, checkerboard, external). Sync/blanking are delayed |
// |               to line up with a PIX_LATENCY-cycle external source.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int PIX_LATENCY = 2,
  parameter int COLOR_W     = 8,
  parameter int CHECK_LOG2  = 5,
  localparam int c_h_total  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int c_v_total  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int c_xw       = $clog2(c_h_total),
  localparam int c_yw       = $clog2(c_v_total)
) (
  input  logic                   clk_25mhz,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  input  logic [3*COLOR_W-1:0]   ext_rgb,
  output logic [c_xw-1:0]        x,
  output logic [c_yw-1:0]        y,
  output logic                   fetch_active,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   de,
  output logic                   frame_start,
  output logic                   line_start,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue
);

  // Comparisons are done one bit wider than the counters so that a boundary
  // equal to the total (e.g. zero back porch) cannot overflow.
  localparam logic [c_xw-1:0] c_x_last   = c_xw'(c_h_total - 1);
  localparam logic [c_yw-1:0] c_y_last   = c_yw'(c_v_total - 1);
  localparam logic [c_xw:0]   c_h_act    = (c_xw+1)'(H_ACTIVE);
  localparam logic [c_xw:0]   c_hs_start = (c_xw+1)'(H_ACTIVE + H_FRONT);
  localparam logic [c_xw:0]   c_hs_end   = (c_xw+1)'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [c_yw:0]   c_v_act    = (c_yw+1)'(V_ACTIVE);
  localparam logic [c_yw:0]   c_vs_start = (c_yw+1)'(V_ACTIVE + V_FRONT);
  localparam logic [c_yw:0]   c_vs_end   = (c_yw+1)'(V_ACTIVE + V_FRONT + V_SYNC);

  // Colour bar width; guarded so tiny test configurations never divide by zero.
  localparam int              c_bar_w    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam logic [c_xw-1:0] c_bar_div  = c_xw'(c_bar_w);
  localparam logic [c_xw-1:0] c_bar_max  = c_xw'(7);

  localparam logic [1:0] c_mode_solid = 2'd0;
  localparam logic [1:0] c_mode_bars  = 2'd1;
  localparam logic [1:0] c_mode_check = 2'd2;
  localparam logic [1:0] c_mode_ext   = 2'd3;

  // Pipeline word: {hs, vs, de, frame, line, ext_sel, colour}
  localparam int c_pw = 6 + 3 * COLOR_W;

  logic [c_xw-1:0]        r_x;
  logic [c_yw-1:0]        r_y;
  logic [1:0]             r_mode;
  logic [3*COLOR_W-1:0]   r_solid;

  logic                   w_origin;
  logic                   w_line0;
  logic                   w_fetch;
  logic                   w_hs_raw;
  logic                   w_vs_raw;
  logic [1:0]             w_mode;
  logic [3*COLOR_W-1:0]   w_solid;
  logic [c_xw-1:0]        w_bar_q;
  logic [2:0]             w_bar;
  logic                   w_chk;
  logic                   w_is_ext;
  logic [3*COLOR_W-1:0]   w_colour;
  logic [c_pw-1:0]        w_head;
  logic [c_pw-1:0]        w_tail;

  logic                   r_hs;
  logic                   r_vs;
  logic                   r_de;
  logic                   r_fs;
  logic                   r_ls;
  logic [3*COLOR_W-1:0]   r_rgb;

  // Pixel/line counters: x wraps at end of line, y advances on that wrap.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (enable) begin
      if (r_x == c_x_last) begin
        r_x <= '0;
        r_y <= (r_y == c_y_last) ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign w_origin = (r_x == '0) && (r_y == '0);
  assign w_line0  = (r_x == '0);
  assign w_fetch  = ({1'b0, r_x} < c_h_act) && ({1'b0, r_y} < c_v_act);
  assign w_hs_raw = ({1'b0, r_x} >= c_hs_start) && ({1'b0, r_x} < c_hs_end);
  assign w_vs_raw = ({1'b0, r_y} >= c_vs_start) && ({1'b0, r_y} < c_vs_end);

  // Shadow the pattern selection at the top of each frame so mid-frame
  // changes never tear the picture.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_mode  <= c_mode_solid;
      r_solid <= '0;
    end else if (enable && w_origin) begin
      r_mode  <= mode;
      r_solid <= solid_rgb;
    end
  end

  // Pixel (0,0) itself must already use the newly sampled settings.
  assign w_mode   = w_origin ? mode : r_mode;
  assign w_solid  = w_origin ? solid_rgb : r_solid;
  assign w_is_ext = (w_mode == c_mode_ext);

  assign w_bar_q  = r_x / c_bar_div;
  assign w_bar    = (w_bar_q > c_bar_max) ? 3'd7 : w_bar_q[2:0];
  assign w_chk    = r_x[CHECK_LOG2] ^ r_y[CHECK_LOG2];

  // Internal pattern colour; bar order is white, yellow, cyan, green,
  // magenta, red, blue, black, which maps directly onto the bar index bits.
  always_comb begin
    w_colour = '0;
    case (w_mode)
      c_mode_solid: w_colour = w_solid;
      c_mode_bars:  w_colour = {{COLOR_W{~w_bar[1]}}, {COLOR_W{~w_bar[2]}},
                                {COLOR_W{~w_bar[0]}}};
      c_mode_check: w_colour = w_chk ? {(3*COLOR_W){1'b1}} : '0;
      default:      w_colour = '0;
    endcase
  end

  assign w_head = {w_hs_raw, w_vs_raw, w_fetch, w_origin, w_line0, w_is_ext, w_colour};

  generate
    if (PIX_LATENCY > 0) begin : g_pipe
      logic [c_pw-1:0] r_pipe [PIX_LATENCY];

      // Delay line matching the upstream pixel source latency; stalls with enable.
      always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIX_LATENCY; i++) begin
            r_pipe[i] <= '0;
          end
        end else if (enable) begin
          r_pipe[0] <= w_head;
          for (int i = 1; i < PIX_LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign w_tail = r_pipe[PIX_LATENCY-1];
    end else begin : g_no_pipe
      assign w_tail = w_head;
    end
  endgenerate

  // Output stage: apply sync polarity, take external colour here so it needs
  // no extra delay, and blank colour outside the active area.
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      r_hs  <= ~HS_POL;
      r_vs  <= ~VS_POL;
      r_de  <= 1'b0;
      r_fs  <= 1'b0;
      r_ls  <= 1'b0;
      r_rgb <= '0;
    end else if (enable) begin
      r_hs  <= w_tail[c_pw-1] ? HS_POL : ~HS_POL;
      r_vs  <= w_tail[c_pw-2] ? VS_POL : ~VS_POL;
      r_de  <= w_tail[c_pw-3];
      r_fs  <= w_tail[c_pw-4];
      r_ls  <= w_tail[c_pw-5];
      if (w_tail[c_pw-3]) begin
        r_rgb <= w_tail[c_pw-6] ? ext_rgb : w_tail[3*COLOR_W-1:0];
      end else begin
        r_rgb <= '0;
      end
    end
  end

  assign x            = r_x;
  assign y            = r_y;
  assign fetch_active = w_fetch;
  assign h_sync       = r_hs;
  assign v_sync       = r_vs;
  assign de           = r_de;
  assign frame_start  = r_fs;
  assign line_start   = r_ls;
  assign red          = r_rgb[3*COLOR_W-1:2*COLOR_W];
  assign green        = r_rgb[2*COLOR_W-1:COLOR_W];
  assign blue         = r_rgb[COLOR_W-1:0];

endmodule
`default_nettype wire
